// File: rtl/shift_arbiter.sv
// Round-robin sharing of one left/right barrel shifter pair between two issue slots,
// with a single registered, ID-tagged result stage and a saturating refusal counter.
module shift_arbiter #(
    parameter int N   = 24,
    parameter int SEL = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           a_valid,
    output logic           a_ready,
    input  logic [N-1:0]   a_data,
    input  logic [SEL-1:0] a_amt,
    input  logic           a_dir,
    input  logic           b_valid,
    output logic           b_ready,
    input  logic [N-1:0]   b_data,
    input  logic [SEL-1:0] b_amt,
    input  logic           b_dir,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [N-1:0]   rsp_data,
    output logic [7:0]     busy_cnt
);

    // Amounts at or beyond the data width flush to zero in both directions.
    function automatic logic [N-1:0] barrel_shift(input logic [N-1:0] d,
                                                  input logic [SEL-1:0] amt,
                                                  input logic dir);
        logic [N-1:0] sh_left;
        logic [N-1:0] sh_right;
        sh_left  = d << amt;
        sh_right = d >> amt;
        if (int'(amt) >= N)
            return '0;
        return dir ? sh_right : sh_left;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] x);
        return (x == 8'hFF) ? x : x + 8'd1;
    endfunction

    logic           vld_p1_q, vld_p1_d;
    logic           id_p1_q, id_p1_d;
    logic [N-1:0]   data_p1_q, data_p1_d;
    logic           last_q, last_d;
    logic [7:0]     busy_q, busy_d;

    logic           free;
    logic           grant_a, grant_b;
    logic           accept;
    logic [N-1:0]   op_data;
    logic [SEL-1:0] op_amt;
    logic           op_dir;

    always_comb begin
        free    = ~vld_p1_q | rsp_ready;
        // last_q = 1 means B won last, so A takes the next contested cycle.
        grant_a = a_valid & (~b_valid | last_q);
        grant_b = b_valid & (~a_valid | ~last_q);
        a_ready = free & grant_a & ~rst;
        b_ready = free & grant_b & ~rst;
        accept  = a_ready | b_ready;

        op_data = grant_b ? b_data : a_data;
        op_amt  = grant_b ? b_amt  : a_amt;
        op_dir  = grant_b ? b_dir  : a_dir;

        vld_p1_d  = vld_p1_q;
        id_p1_d   = id_p1_q;
        data_p1_d = data_p1_q;
        last_d    = last_q;
        busy_d    = busy_q;

        if (accept) begin
            vld_p1_d  = 1'b1;
            id_p1_d   = grant_b;
            data_p1_d = barrel_shift(op_data, op_amt, op_dir);
            last_d    = grant_b;
        end else if (rsp_ready) begin
            vld_p1_d = 1'b0;
        end

        if ((a_valid & ~a_ready) | (b_valid & ~b_ready))
            busy_d = sat_inc(busy_q);
    end

    // ---- result stage p1 ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q  <= 1'b0;
            id_p1_q   <= 1'b0;
            data_p1_q <= '0;
            last_q    <= 1'b1;
            busy_q    <= 8'd0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            id_p1_q   <= id_p1_d;
            data_p1_q <= data_p1_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
        end
    end

    assign rsp_valid = vld_p1_q;
    assign rsp_id    = id_p1_q;
    assign rsp_data  = data_p1_q;
    assign busy_cnt  = busy_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed and randomized bench for shift_arbiter against a cycle-level reference model.
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, a_ready, a_dir;
    logic [23:0] a_data;
    logic [4:0]  a_amt;
    logic        b_valid, b_ready, b_dir;
    logic [23:0] b_data;
    logic [4:0]  b_amt;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [23:0] rsp_data;
    logic [7:0]  busy_cnt;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit          m_vld;
    bit          m_id;
    logic [23:0] m_data;
    bit          m_last;   // 1 = B won last
    int          m_busy;
    bit          m_acc;

    shift_arbiter #(.N(24), .SEL(5)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_amt(a_amt), .a_dir(a_dir),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_amt(b_amt), .b_dir(b_dir),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] ref_shift(input logic [23:0] d, input int amt, input bit dir);
        longint unsigned p, v;
        if (amt >= 24) return 24'h0;
        p = longint'(1) << amt;
        if (dir) v = longint'(d) / p;
        else     v = (longint'(d) * p) % (longint'(1) << 24);
        return v[23:0];
    endfunction

    // -1 none, 0 A, 1 B
    function automatic int winner();
        if (a_valid && b_valid) return m_last ? 0 : 1;
        if (a_valid) return 0;
        if (b_valid) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_vld = 0; m_id = 0; m_data = 24'h0; m_last = 1; m_busy = 0; m_acc = 0;
    endtask

    // Check all outputs mid-cycle, advance the model, then move to just after the edge.
    task automatic tick();
        bit free;
        int w;
        bit ea, eb;
        @(negedge clk);
        free = !m_vld || rsp_ready;
        w    = winner();
        ea   = !rst && free && (w == 0);
        eb   = !rst && free && (w == 1);
        chk("a_ready", a_ready, ea);
        chk("b_ready", b_ready, eb);
        chk("rsp_valid", rsp_valid, m_vld);
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_data", rsp_data, m_data);
        chk("busy_cnt", busy_cnt, m_busy);
        m_acc = 0;
        if (rst) begin
            model_reset();
        end else begin
            if ((a_valid && !ea) || (b_valid && !eb))
                m_busy = (m_busy < 255) ? m_busy + 1 : 255;
            if (ea || eb) begin
                m_vld  = 1;
                m_id   = eb;
                m_data = eb ? ref_shift(b_data, b_amt, b_dir) : ref_shift(a_data, a_amt, a_dir);
                m_last = eb;
                m_acc  = 1;
            end else if (rsp_ready) begin
                m_vld = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [23:0] held_data;
    logic        held_id;
    logic        a_acc_l, b_acc_l;

    typedef struct { logic [23:0] d; logic [4:0] amt; logic dir; logic [23:0] exp; } bnd_t;
    bnd_t bnd[8];

    initial begin
        rst = 1; a_valid = 0; b_valid = 0; rsp_ready = 0;
        a_data = 0; a_amt = 0; a_dir = 0; b_data = 0; b_amt = 0; b_dir = 0;
        model_reset();
        @(posedge clk); #1;
        tick();
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy_cnt, 0);

        // 1: A only
        rst = 0; a_valid = 1; a_data = 24'h0000F1; a_amt = 4; a_dir = 0; rsp_ready = 1;
        #1 chk("t1_a_ready", a_ready, 1);
        tick();
        a_valid = 0;
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_id", rsp_id, 0);
        chk("t1_rsp_data", rsp_data, 24'h000F10);
        tick();

        // 2: contested alternation from a fresh reset
        rst = 1; tick(); rst = 0;
        a_valid = 1; a_data = 24'h800000; a_amt = 1;  a_dir = 1;
        b_valid = 1; b_data = 24'h000001; b_amt = 23; b_dir = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_id", rsp_id, i % 2);
            chk("t2_data", rsp_data, (i % 2) ? 24'h800000 : 24'h400000);
            chk("t2_busy", busy_cnt, i + 1);
        end
        b_valid = 0;

        // 3: shift-amount boundaries through slot A
        bnd[0] = '{24'h123456, 5'd0,  1'b0, 24'h123456};
        bnd[1] = '{24'h123456, 5'd0,  1'b1, 24'h123456};
        bnd[2] = '{24'h000001, 5'd23, 1'b0, 24'h800000};
        bnd[3] = '{24'h800000, 5'd23, 1'b1, 24'h000001};
        bnd[4] = '{24'hFFFFFF, 5'd24, 1'b0, 24'h000000};
        bnd[5] = '{24'hFFFFFF, 5'd24, 1'b1, 24'h000000};
        bnd[6] = '{24'hFFFFFF, 5'd31, 1'b0, 24'h000000};
        bnd[7] = '{24'hFFFFFF, 5'd31, 1'b1, 24'h000000};
        for (int i = 0; i < 8; i++) begin
            a_valid = 1; a_data = bnd[i].d; a_amt = bnd[i].amt; a_dir = bnd[i].dir;
            tick();
            chk("t3_data", rsp_data, bnd[i].exp);
        end

        // 4: backpressure with both requesters waiting
        a_data = 24'h00ABCD; a_amt = 3; a_dir = 0;
        b_valid = 1; b_data = 24'hF0F0F0; b_amt = 5; b_dir = 1;
        tick();
        rsp_ready = 0;
        held_data = rsp_data; held_id = rsp_id;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_held_data", rsp_data, held_data);
            chk("t4_held_id", rsp_id, held_id);
            chk("t4_held_valid", rsp_valid, 1);
        end
        rsp_ready = 1;
        #1 chk("t4_ready_any", a_ready | b_ready, 1);
        tick();
        chk("t4_reload_valid", rsp_valid, 1);
        chk("t4_reload_id", rsp_id, !held_id);

        // 5: reset while holding with both valid
        rsp_ready = 0; tick();
        rst = 1; tick(); rst = 0;
        chk("t5_valid", rsp_valid, 0);
        chk("t5_busy", busy_cnt, 0);
        rsp_ready = 1; tick();
        chk("t5_first_id", rsp_id, 0);

        // 6: busy_cnt saturation
        a_valid = 0; b_valid = 1; rsp_ready = 0;
        for (int i = 0; i < 300; i++) tick();
        chk("t6_busy_sat", busy_cnt, 255);

        // 7: randomized traffic honouring hold-until-ready
        rst = 1; tick(); rst = 0;
        a_valid = 0; b_valid = 0;
        a_acc_l = 1; b_acc_l = 1;
        for (int i = 0; i < 500; i++) begin
            if (!a_valid || a_acc_l) begin
                a_valid = ($urandom_range(0, 3) != 0);
                a_data = 24'($urandom); a_amt = 5'($urandom); a_dir = 1'($urandom);
            end
            if (!b_valid || b_acc_l) begin
                b_valid = ($urandom_range(0, 3) != 0);
                b_data = 24'($urandom); b_amt = 5'($urandom); b_dir = 1'($urandom);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 59) == 0);
            #1;
            a_acc_l = a_ready; b_acc_l = b_ready;
            tick();
            if (rst) begin a_acc_l = 1; b_acc_l = 1; end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
